// File: rtl/accel_poller.sv
// accel_poller: SPI mode-0 burst reader polling an accelerometer.
// Optional macro ACCEL_AVG_EN: 4-sample running mean per axis.
module accel_poller #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned AXES        = 3,
   parameter int unsigned POLL_CYCLES = 100000,
   parameter logic [7:0]  REG_ADDR    = 8'h08
) (
   input  logic                   clk,
   input  logic                   rstbt,
   input  logic                   en,
   input  logic                   miso,
   output logic                   sclk,
   output logic                   mosi,
   output logic                   cs_n,
   output logic [AXES*DATA_W-1:0] axis_data,
   output logic                   valid,
   output logic                   busy
);
   localparam int unsigned W     = AXES * DATA_W;
   localparam int unsigned TOTAL = 16 + W;
   localparam int unsigned BW    = $clog2(TOTAL + 1);

   localparam logic [23:0]   DIV_LAST   = 24'(CLK_DIV - 1);
   localparam logic [23:0]   POLL_LAST  = 24'(POLL_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(TOTAL - 1);
   localparam logic [BW-1:0] ADDR_FIRST = BW'(8);
   localparam logic [BW-1:0] READ_FIRST = BW'(16);
   localparam logic [BW-1:0] RX_FROM    = BW'(15);

   typedef enum logic [2:0] {
      IDLE, WAIT, SETUP, CMD, ADDR, READ, HOLD, DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [23:0]   r_cnt;
   logic [BW-1:0] r_bit;
   logic          r_phase;
   logic [15:0]   r_tx;
   logic [W-1:0]  r_rx;
   logic [W-1:0]  r_data;

   logic          w_shift;
   logic          w_half_end;
   logic          w_last_bit;
   logic          w_rise;
   logic          w_fall;
   logic          w_load;
   logic [BW-1:0] w_bit_nx;
   logic [W-1:0]  w_sample;
   logic [W-1:0]  w_result;

   assign w_shift    = (r_state == CMD) || (r_state == ADDR) ||
                       (r_state == READ);
   assign w_half_end = (r_cnt == DIV_LAST);
   assign w_last_bit = (r_bit == BIT_LAST);
   assign w_bit_nx   = r_bit + 1'b1;
   // r_phase=0 is the high half of a bit; SETUP is the first low half
   assign w_rise     = w_half_end &&
                       ((r_state == SETUP) || (w_shift && r_phase));
   assign w_fall     = w_half_end && w_shift && !r_phase;
   assign w_load     = (r_state == HOLD) && w_half_end;

   always_ff @(posedge clk or negedge rstbt) begin
      if (!rstbt) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (en) w_next = SETUP;
         end
         WAIT: begin
            if (!en)                     w_next = IDLE;
            else if (r_cnt == POLL_LAST) w_next = SETUP;
         end
         SETUP: begin
            if (w_half_end) w_next = CMD;
         end
         CMD, ADDR, READ: begin
            if (w_fall && w_last_bit) begin
               w_next = HOLD;
            end else if (w_rise) begin
               if (w_bit_nx >= READ_FIRST)      w_next = READ;
               else if (w_bit_nx >= ADDR_FIRST) w_next = ADDR;
               else                             w_next = CMD;
            end
         end
         HOLD: begin
            if (w_half_end) w_next = DONE;
         end
         DONE: begin
            w_next = en ? WAIT : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstbt) begin
      if (!rstbt) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_phase <= 1'b0;
         r_tx    <= '0;
         r_rx    <= '0;
      end else begin
         if ((w_next != r_state) || (w_shift && w_half_end) ||
             (r_state == IDLE) || (r_state == DONE))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 24'd1;

         if (r_state == SETUP) r_bit <= '0;
         else if (w_rise)      r_bit <= w_bit_nx;

         if (w_fall)      r_phase <= 1'b1;
         else if (w_rise) r_phase <= 1'b0;

         // first command bit is presented as cs_n falls
         if ((w_next == SETUP) && (r_state != SETUP))
            r_tx <= {8'h0B, REG_ADDR};
         else if (w_fall)
            r_tx <= {r_tx[14:0], 1'b0};

         if (w_rise && w_shift && (r_bit >= RX_FROM))
            r_rx <= {r_rx[W-2:0], miso};
      end
   end

   // first received word is axis 0, placed in the low bits
   for (genvar a = 0; a < AXES; a++) begin : g_ax
      assign w_sample[a*DATA_W +: DATA_W] =
         r_rx[(AXES-1-a)*DATA_W +: DATA_W];
   end

`ifdef ACCEL_AVG_EN
   logic [W-1:0] r_h1;
   logic [W-1:0] r_h2;
   logic [W-1:0] r_h3;

   for (genvar a = 0; a < AXES; a++) begin : g_avg
      logic [DATA_W+1:0] w_sum;
      assign w_sum = {2'b00, w_sample[a*DATA_W +: DATA_W]} +
                     {2'b00, r_h1[a*DATA_W +: DATA_W]} +
                     {2'b00, r_h2[a*DATA_W +: DATA_W]} +
                     {2'b00, r_h3[a*DATA_W +: DATA_W]};
      assign w_result[a*DATA_W +: DATA_W] = w_sum[DATA_W+1:2];
   end

   always_ff @(posedge clk or negedge rstbt) begin
      if (!rstbt) begin
         r_h1 <= '0;
         r_h2 <= '0;
         r_h3 <= '0;
      end else if (w_load) begin
         r_h1 <= w_sample;
         r_h2 <= r_h1;
         r_h3 <= r_h2;
      end
   end
`else
   assign w_result = w_sample;
`endif

   always_ff @(posedge clk or negedge rstbt) begin
      if (!rstbt)      r_data <= '0;
      else if (w_load) r_data <= w_result;
   end

   assign sclk      = w_shift && !r_phase;
   assign cs_n      = !(w_shift || (r_state == SETUP) ||
                        (r_state == HOLD));
   assign mosi      = !cs_n && r_tx[15];
   assign busy      = (r_state != IDLE) && (r_state != WAIT);
   assign valid     = (r_state == DONE);
   assign axis_data = r_data;

endmodule

// File: tb/tb_accel_poller.sv
// Directed bench for accel_poller: two configurations driven by
// simple SPI sensor models (a third AXES=1 unit with ACCEL_AVG_EN).
module tb_accel_poller;
   logic clk   = 1'b0;
   logic rstbt = 1'b0;
   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

`ifdef ACCEL_AVG_EN
   localparam logic [23:0] EXP0A = 24'h150D04;
   localparam logic [23:0] EXP0B = 24'h2B1A09;
   localparam logic [47:0] EXP1A = 48'h1E21150482AF;
   localparam logic [47:0] EXP1B = 48'h5E21E20D12F3;
   localparam logic [11:0] EXP1A_AX3 = 12'h1E2;
`else
   localparam logic [23:0] EXP0A = 24'h563412;
   localparam logic [23:0] EXP0B = 24'h563412;
   localparam logic [47:0] EXP1A = 48'h789456123ABC;
   localparam logic [47:0] EXP1B = 48'hFFF333222111;
   localparam logic [11:0] EXP1A_AX3 = 12'h789;
`endif

   // unit 0: default geometry, CLK_DIV=4, POLL_CYCLES=25
   logic        en0 = 1'b0;
   logic        miso0 = 1'b0;
   logic        sclk0, mosi0, cs_n0, valid0, busy0;
   logic [23:0] ad0;
   logic [23:0] s0_data = '0;

   accel_poller #(.POLL_CYCLES(25)) u_dut0 (
      .clk(clk), .rstbt(rstbt), .en(en0), .miso(miso0),
      .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0),
      .axis_data(ad0), .valid(valid0), .busy(busy0));

   // unit 1: CLK_DIV=2, AXES=4, DATA_W=12, POLL_CYCLES=10
   logic        en1 = 1'b0;
   logic        miso1 = 1'b0;
   logic        sclk1, mosi1, cs_n1, valid1, busy1;
   logic [47:0] ad1;
   logic [47:0] s1_data = '0;

   accel_poller #(.CLK_DIV(2), .DATA_W(12), .AXES(4),
                  .POLL_CYCLES(10)) u_dut1 (
      .clk(clk), .rstbt(rstbt), .en(en1), .miso(miso1),
      .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1),
      .axis_data(ad1), .valid(valid1), .busy(busy1));

   // per-frame monitors for unit 0
   int          f0 = 0, rf0 = 0, sf0 = 0, n0 = 0, r0 = 0;
   int          lowc0 = 0, vc0 = 0;
   logic        pcs0 = 1'b1;
   logic [15:0] mcap0 = '0;
   longint      last0 = 0, gmin0 = 0, gmax0 = 0;

   always @(negedge cs_n0) f0 = f0 + 1;

   always @(posedge sclk0) begin
      if (rf0 != f0) begin
         rf0 = f0; r0 = 0; mcap0 = '0;
         gmin0 = 64'd1000000; gmax0 = 0;
      end else begin
         if ($time - last0 < gmin0) gmin0 = $time - last0;
         if ($time - last0 > gmax0) gmax0 = $time - last0;
      end
      last0 = $time;
      if (r0 < 16) mcap0 = {mcap0[14:0], mosi0};
      r0 = r0 + 1;
   end

   always @(negedge sclk0) begin
      if (sf0 != f0) begin sf0 = f0; n0 = 0; end
      n0 = n0 + 1;
      #1 miso0 = (n0 >= 16 && n0 < 40) ? s0_data[39-n0] : 1'b0;
   end

   always @(negedge clk) begin
      if (cs_n0 === 1'b0) begin
         if (pcs0 === 1'b1) lowc0 = 0;
         lowc0 = lowc0 + 1;
      end
      if (valid0 === 1'b1) vc0 = vc0 + 1;
      pcs0 = cs_n0;
   end

   // per-frame monitors for unit 1
   int     f1 = 0, rf1 = 0, sf1 = 0, n1 = 0, r1 = 0;
   int     lowc1 = 0, vc1 = 0;
   logic   pcs1 = 1'b1;
   longint last1 = 0, gmin1 = 0, gmax1 = 0;

   always @(negedge cs_n1) f1 = f1 + 1;

   always @(posedge sclk1) begin
      if (rf1 != f1) begin
         rf1 = f1; r1 = 0;
         gmin1 = 64'd1000000; gmax1 = 0;
      end else begin
         if ($time - last1 < gmin1) gmin1 = $time - last1;
         if ($time - last1 > gmax1) gmax1 = $time - last1;
      end
      last1 = $time;
      r1 = r1 + 1;
   end

   always @(negedge sclk1) begin
      if (sf1 != f1) begin sf1 = f1; n1 = 0; end
      n1 = n1 + 1;
      #1 miso1 = (n1 >= 16 && n1 < 64) ? s1_data[63-n1] : 1'b0;
   end

   always @(negedge clk) begin
      if (cs_n1 === 1'b0) begin
         if (pcs1 === 1'b1) lowc1 = 0;
         lowc1 = lowc1 + 1;
      end
      if (valid1 === 1'b1) vc1 = vc1 + 1;
      pcs1 = cs_n1;
   end

`ifdef ACCEL_AVG_EN
   // unit 2: single axis, exercises the running mean
   logic       en2 = 1'b0;
   logic       miso2 = 1'b0;
   logic       sclk2, mosi2, cs_n2, valid2, busy2;
   logic [7:0] ad2;
   logic [7:0] s2_data = '0;
   int         f2 = 0, sf2 = 0, n2 = 0;

   accel_poller #(.CLK_DIV(2), .AXES(1), .POLL_CYCLES(1)) u_dut2 (
      .clk(clk), .rstbt(rstbt), .en(en2), .miso(miso2),
      .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2),
      .axis_data(ad2), .valid(valid2), .busy(busy2));

   always @(negedge cs_n2) f2 = f2 + 1;

   always @(negedge sclk2) begin
      if (sf2 != f2) begin sf2 = f2; n2 = 0; end
      n2 = n2 + 1;
      #1 miso2 = (n2 >= 16 && n2 < 24) ? s2_data[23-n2] : 1'b0;
   end
`endif

   task automatic test_reset();
      rstbt = 1'b0;
      repeat (3) @(negedge clk);
      nchk++;
      if ({cs_n0, sclk0, mosi0, valid0, busy0} !== 5'b10000) begin
         nfail++;
         $display("FAIL reset_ctl0: got %b required 10000",
                  {cs_n0, sclk0, mosi0, valid0, busy0});
      end
      nchk++;
      if (ad0 !== 24'h0) begin
         nfail++;
         $display("FAIL reset_data0: got %h required 0", ad0);
      end
      nchk++;
      if ({cs_n1, sclk1, mosi1, valid1, busy1} !== 5'b10000) begin
         nfail++;
         $display("FAIL reset_ctl1: got %b required 10000",
                  {cs_n1, sclk1, mosi1, valid1, busy1});
      end
      rstbt = 1'b1;
      repeat (3) @(negedge clk);
      nchk++;
      if ({cs_n0, busy0} !== 2'b10) begin
         nfail++;
         $display("FAIL idle_no_en: cs_n/busy %b required 10",
                  {cs_n0, busy0});
      end
   endtask

   task automatic test_frame();
      int base;
      base    = vc0;
      s0_data = 24'h123456;
      en0     = 1'b1;
      @(negedge clk);
      nchk++;
      if (cs_n0 !== 1'b0) begin
         nfail++;
         $display("FAIL first_poll: cs_n=%b required 0", cs_n0);
      end
      for (int i = 0; i < 1000 && valid0 !== 1'b1; i++)
         @(negedge clk);
      nchk++;
      if (valid0 !== 1'b1) begin
         nfail++;
         $display("FAIL frame0_timeout: valid=%b required 1", valid0);
      end
      nchk++;
      if (r0 != 40) begin
         nfail++;
         $display("FAIL frame0_rises: got %0d required 40", r0);
      end
      nchk++;
      if (mcap0 !== 16'h0B08) begin
         nfail++;
         $display("FAIL frame0_mosi: got %h required 0b08", mcap0);
      end
      nchk++;
      if (lowc0 != 324) begin
         nfail++;
         $display("FAIL frame0_cs_low: got %0d required 324", lowc0);
      end
      nchk++;
      if (gmin0 != 80 || gmax0 != 80) begin
         nfail++;
         $display("FAIL frame0_period: min %0d max %0d required 80",
                  gmin0, gmax0);
      end
      nchk++;
      if (ad0 !== EXP0A) begin
         nfail++;
         $display("FAIL frame0_data: got %h required %h", ad0, EXP0A);
      end
      nchk++;
      if ({cs_n0, sclk0, mosi0, busy0} !== 4'b1001) begin
         nfail++;
         $display("FAIL done_levels: got %b required 1001",
                  {cs_n0, sclk0, mosi0, busy0});
      end
      en0 = 1'b0;
      repeat (40) @(negedge clk);
      nchk++;
      if (vc0 - base != 1) begin
         nfail++;
         $display("FAIL frame0_valid_cnt: got %0d required 1",
                  vc0 - base);
      end
      nchk++;
      if (ad0 !== EXP0A) begin
         nfail++;
         $display("FAIL frame0_hold: got %h required %h", ad0, EXP0A);
      end
   endtask

   task automatic test_poll_interval();
      int idle;
      s1_data = {12'hABC, 12'h123, 12'h456, 12'h789};
      en1     = 1'b1;
      for (int i = 0; i < 1000 && valid1 !== 1'b1; i++)
         @(negedge clk);
      nchk++;
      if (valid1 !== 1'b1) begin
         nfail++;
         $display("FAIL frame1_timeout: valid=%b required 1", valid1);
      end
      nchk++;
      if (r1 != 64) begin
         nfail++;
         $display("FAIL frame1_rises: got %0d required 64", r1);
      end
      nchk++;
      if (lowc1 != 258) begin
         nfail++;
         $display("FAIL frame1_cs_low: got %0d required 258", lowc1);
      end
      nchk++;
      if (gmin1 != 40 || gmax1 != 40) begin
         nfail++;
         $display("FAIL frame1_period: min %0d max %0d required 40",
                  gmin1, gmax1);
      end
      nchk++;
      if (ad1 !== EXP1A) begin
         nfail++;
         $display("FAIL frame1_data: got %h required %h", ad1, EXP1A);
      end
      nchk++;
      if (ad1[47:36] !== EXP1A_AX3) begin
         nfail++;
         $display("FAIL frame1_axis3: got %h required %h",
                  ad1[47:36], EXP1A_AX3);
      end
      s1_data = {12'h111, 12'h222, 12'h333, 12'hFFF};
      idle = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cs_n1 === 1'b0) break;
         idle++;
      end
      nchk++;
      if (idle != 10) begin
         nfail++;
         $display("FAIL poll_gap1: got %0d required 10", idle);
      end
   endtask

   task automatic test_en_drop();
      int base;
      base = vc1 - 1;
      for (int i = 0; i < 500 && r1 < 30; i++)
         @(negedge clk);
      nchk++;
      if (ad1 !== EXP1A) begin
         nfail++;
         $display("FAIL no_partial: got %h required %h", ad1, EXP1A);
      end
      en1 = 1'b0;
      for (int i = 0; i < 1000 && valid1 !== 1'b1; i++)
         @(negedge clk);
      nchk++;
      if (valid1 !== 1'b1) begin
         nfail++;
         $display("FAIL drop_timeout: valid=%b required 1", valid1);
      end
      nchk++;
      if (ad1 !== EXP1B) begin
         nfail++;
         $display("FAIL drop_data: got %h required %h", ad1, EXP1B);
      end
      repeat (60) @(negedge clk);
      nchk++;
      if (vc1 - base != 2) begin
         nfail++;
         $display("FAIL drop_valid_cnt: got %0d required 2", vc1 - base);
      end
      nchk++;
      if ({cs_n1, busy1} !== 2'b10) begin
         nfail++;
         $display("FAIL drop_idle: cs_n/busy %b required 10",
                  {cs_n1, busy1});
      end
   endtask

   task automatic test_reset_mid();
      int base;
      base = vc0;
      en0  = 1'b1;
      for (int i = 0; i < 500 && r0 < 10; i++)
         @(negedge clk);
      @(posedge sclk0);
      #3 rstbt = 1'b0;
      #1;
      nchk++;
      if ({cs_n0, sclk0, mosi0, busy0} !== 4'b1000) begin
         nfail++;
         $display("FAIL rst_mid_ctl: got %b required 1000",
                  {cs_n0, sclk0, mosi0, busy0});
      end
      nchk++;
      if (ad0 !== 24'h0) begin
         nfail++;
         $display("FAIL rst_mid_data: got %h required 0", ad0);
      end
      en0 = 1'b0;
      repeat (3) @(negedge clk);
      rstbt = 1'b1;
      repeat (30) @(negedge clk);
      nchk++;
      if (vc0 != base || cs_n0 !== 1'b1) begin
         nfail++;
         $display("FAIL rst_mid_valid: pulses %0d cs_n %b required 0 1",
                  vc0 - base, cs_n0);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      int idle;
      base = vc0;
      en0  = 1'b1;
      @(negedge clk);
      nchk++;
      if (cs_n0 !== 1'b0) begin
         nfail++;
         $display("FAIL start_after_rst: cs_n=%b required 0", cs_n0);
      end
      for (int i = 0; i < 1000 && valid0 !== 1'b1; i++)
         @(negedge clk);
      nchk++;
      if (valid0 !== 1'b1 || ad0 !== EXP0A) begin
         nfail++;
         $display("FAIL b2b_a: valid %b data %h required 1 %h",
                  valid0, ad0, EXP0A);
      end
      idle = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cs_n0 === 1'b0) break;
         idle++;
      end
      nchk++;
      if (idle != 25) begin
         nfail++;
         $display("FAIL poll_gap0: got %0d required 25", idle);
      end
      for (int i = 0; i < 1000 && valid0 !== 1'b1; i++)
         @(negedge clk);
      nchk++;
      if (valid0 !== 1'b1 || ad0 !== EXP0B) begin
         nfail++;
         $display("FAIL b2b_b: valid %b data %h required 1 %h",
                  valid0, ad0, EXP0B);
      end
      repeat (5) @(negedge clk);
      nchk++;
      if ({cs_n0, busy0} !== 2'b10) begin
         nfail++;
         $display("FAIL wait_levels: cs_n/busy %b required 10",
                  {cs_n0, busy0});
      end
      en0 = 1'b0;
      @(negedge clk);
      en0 = 1'b1;
      @(negedge clk);
      nchk++;
      if (cs_n0 !== 1'b0) begin
         nfail++;
         $display("FAIL wait_abort: cs_n=%b required 0", cs_n0);
      end
      en0 = 1'b0;
      for (int i = 0; i < 1000 && valid0 !== 1'b1; i++)
         @(negedge clk);
      repeat (60) @(negedge clk);
      nchk++;
      if (vc0 - base != 3 || cs_n0 !== 1'b1) begin
         nfail++;
         $display("FAIL b2b_count: pulses %0d cs_n %b required 3 1",
                  vc0 - base, cs_n0);
      end
   endtask

`ifdef ACCEL_AVG_EN
   task automatic test_avg();
      logic [7:0] smp [5];
      logic [7:0] exp [5];
      smp = '{8'd8, 8'd8, 8'd8, 8'd8, 8'd16};
      exp = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10};
      s2_data = smp[0];
      en2 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 1000 && valid2 !== 1'b1; i++)
            @(negedge clk);
         nchk++;
         if (valid2 !== 1'b1 || ad2 !== exp[k]) begin
            nfail++;
            $display("FAIL avg_%0d: valid %b data %0d required 1 %0d",
                     k, valid2, ad2, exp[k]);
         end
         if (k < 4) s2_data = smp[k+1];
         else       en2 = 1'b0;
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_poll_interval();
      test_en_drop();
      test_reset_mid();
      test_back_to_back();
`ifdef ACCEL_AVG_EN
      test_avg();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
